kbd_spi_rx: RTL and testbench



---
 rtl/kbd_spi_rx.sv | 104 ++++++++++
 tb/tb_kbd_spi_rx.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/kbd_spi_rx.sv
// SPI slave receiving the keyboard matrix from the external controller and
// answering port #FE reads with the column data of the selected rows.
module kbd_spi_rx #(
    parameter int         FRAME_BITS = 48,
    parameter logic [3:0] SIG        = 4'b0101
) (
    input  logic       CLK_14MHZ,
    input  logic       CPU_RESET,
    input  logic       KBD_CLK,
    input  logic       KBD_CS,
    input  logic       KBD_DI,
    input  logic [7:0] A_HI,
    output logic [4:0] KD,
    output logic       FRAME_OK,
    output logic       FRAME_ERR
);

    logic [2:0]            clk_sync_q;
    logic [2:0]            cs_sync_q;
    logic [1:0]            di_sync_q;
    logic [FRAME_BITS-1:0] shift_q, shift_d;
    logic [5:0]            cnt_q, cnt_d;
    logic                  ovf_q, ovf_d;
    logic [39:0]           matrix_q, matrix_d;
    logic                  ok_q, ok_d;
    logic                  err_q, err_d;

    logic sclk_rise, cs_fall, cs_rise;
    logic [4:0] pressed;

    assign sclk_rise = clk_sync_q[1] & ~clk_sync_q[2];
    assign cs_fall   = ~cs_sync_q[1] & cs_sync_q[2];
    assign cs_rise   = cs_sync_q[1] & ~cs_sync_q[2];

    // cs_sync_q[2] is the CS level before any edge in this cycle, so a clock
    // rise coinciding with CS rise still shifts before the frame-end check.
    always_comb begin
        shift_d  = shift_q;
        cnt_d    = cnt_q;
        ovf_d    = ovf_q;
        matrix_d = matrix_q;
        ok_d     = 1'b0;
        err_d    = 1'b0;
        if (cs_fall) begin
            cnt_d = 6'd0;
            ovf_d = 1'b0;
        end else if (sclk_rise && !cs_sync_q[2]) begin
            shift_d = {shift_q[FRAME_BITS-2:0], di_sync_q[1]};
            if (cnt_q == 6'd63) begin
                ovf_d = 1'b1;
            end else begin
                cnt_d = cnt_q + 6'd1;
            end
        end
        if (cs_rise) begin
            if (cnt_d == 6'(FRAME_BITS) && !ovf_d &&
                shift_d[FRAME_BITS-1 -: 4] == SIG) begin
                matrix_d = shift_d[39:0];
                ok_d     = 1'b1;
            end else begin
                err_d    = 1'b1;
            end
        end
    end

    always_ff @(posedge CLK_14MHZ or negedge CPU_RESET) begin
        if (!CPU_RESET) begin
            clk_sync_q <= 3'b000;
            cs_sync_q  <= 3'b111;
            di_sync_q  <= 2'b00;
            shift_q    <= '0;
            cnt_q      <= 6'd0;
            ovf_q      <= 1'b0;
            matrix_q   <= 40'd0;
            ok_q       <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            clk_sync_q <= {clk_sync_q[1:0], KBD_CLK};
            cs_sync_q  <= {cs_sync_q[1:0], KBD_CS};
            di_sync_q  <= {di_sync_q[0], KBD_DI};
            shift_q    <= shift_d;
            cnt_q      <= cnt_d;
            ovf_q      <= ovf_d;
            matrix_q   <= matrix_d;
            ok_q       <= ok_d;
            err_q      <= err_d;
        end
    end

    // Row r is selected by A_HI[r] = 0; selected rows are OR'd per column.
    always_comb begin
        pressed = 5'b00000;
        for (int r = 0; r < 8; r++) begin
            for (int b = 0; b < 5; b++) begin
                pressed[b] = pressed[b] | (matrix_q[5*r+b] & ~A_HI[r]);
            end
        end
    end

    assign KD        = ~pressed;
    assign FRAME_OK  = ok_q;
    assign FRAME_ERR = err_q;

endmodule

// File: tb/tb_kbd_spi_rx.sv
// Bench for kbd_spi_rx: spec-level key-matrix model, fixed vector tables,
// corner-case sequences and randomized frames.
module tb_kbd_spi_rx;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       sclk = 1'b0;
    logic       cs = 1'b1;
    logic       di = 1'b0;
    logic [7:0] a_hi = 8'h00;
    logic [4:0] kd;
    logic       frame_ok, frame_err;

    kbd_spi_rx dut (
        .CLK_14MHZ (clk),
        .CPU_RESET (rst_n),
        .KBD_CLK   (sclk),
        .KBD_CS    (cs),
        .KBD_DI    (di),
        .A_HI      (a_hi),
        .KD        (kd),
        .FRAME_OK  (frame_ok),
        .FRAME_ERR (frame_err)
    );

    always #10 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int ok_cnt = 0;
    int err_cnt = 0;
    logic [4:0] kd_at_ok = 5'h00;

    always @(negedge clk) begin
        if (frame_ok) begin
            ok_cnt++;
            kd_at_ok = kd;
        end
        if (frame_err) err_cnt++;
    end

    // keys[row][col] = 1 when pressed
    logic keys [8][5];

    typedef struct {
        logic [7:0] a;
        logic [4:0] kd;
    } vec_t;

    vec_t t1 [3];
    vec_t t2 [3];

    task automatic check(input string name, input int got, input int exp);
        tests++;
        if (got != exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
    endtask

    function automatic logic [4:0] model_kd(input logic [7:0] a);
        logic [4:0] r;
        for (int b = 0; b < 5; b++) begin
            logic p;
            p = 1'b0;
            for (int row = 0; row < 8; row++)
                if (!a[row] && keys[row][b]) p = 1'b1;
            r[b] = !p;
        end
        return r;
    endfunction

    // Returns 1 when the frame must be committed; updates the key model.
    function automatic logic model_frame(input logic [7:0] hdr, input logic [39:0] payload,
                                         input int nbits);
        if (nbits != 48 || hdr[7:4] != 4'b0101) return 1'b0;
        for (int i = 0; i < 40; i++)
            keys[7 - i/5][4 - i%5] = payload[39 - i];
        return 1'b1;
    endfunction

    task automatic model_clear();
        for (int r = 0; r < 8; r++)
            for (int b = 0; b < 5; b++)
                keys[r][b] = 1'b0;
    endtask

    task automatic spi_bit(input logic b);
        @(negedge clk) di = b;
        wait_cyc(4);
        @(negedge clk) sclk = 1'b1;
        wait_cyc(4);
        @(negedge clk) sclk = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] hdr, input logic [39:0] payload,
                              input int nbits, input bit glitch);
        logic [47:0] w;
        w = {hdr, payload};
        @(negedge clk) cs = 1'b0;
        wait_cyc(4);
        if (glitch) begin
            @(negedge clk);
            #2 sclk = 1'b1;
            #5 sclk = 1'b0;
            wait_cyc(4);
        end
        for (int k = 0; k < nbits; k++)
            spi_bit(k < 48 ? w[47-k] : 1'($urandom));
        wait_cyc(4);
        @(negedge clk) cs = 1'b1;
        wait_cyc(6);
    endtask

    task automatic do_frame(input string name, input logic [7:0] hdr,
                            input logic [39:0] payload, input int nbits, input bit glitch);
        int o0, e0;
        logic exp;
        o0 = ok_cnt;
        e0 = err_cnt;
        a_hi = 8'h00;
        send_frame(hdr, payload, nbits, glitch);
        exp = model_frame(hdr, payload, nbits);
        check({name, "_ok"}, ok_cnt - o0, exp ? 1 : 0);
        check({name, "_err"}, err_cnt - e0, exp ? 0 : 1);
        if (exp) check({name, "_kd_at_commit"}, kd_at_ok, model_kd(8'h00));
    endtask

    task automatic apply_table(input string name, input vec_t v);
        @(negedge clk) a_hi = v.a;
        #2 check(name, kd, v.kd);
        check({name, "_model"}, kd, model_kd(v.a));
    endtask

    task automatic check_model(input string name, input logic [7:0] a);
        @(negedge clk) a_hi = a;
        #2 check(name, kd, model_kd(a));
    endtask

    initial begin
        logic [7:0]  hdr;
        logic [39:0] pl;
        int          n, sel, o0, e0;

        t1[0] = '{8'hFE, 5'h1E};
        t1[1] = '{8'hFF, 5'h1F};
        t1[2] = '{8'h00, 5'h1E};
        t2[0] = '{8'h7E, 5'h0E};
        t2[1] = '{8'h7F, 5'h0F};
        t2[2] = '{8'hFE, 5'h1E};
        model_clear();

        wait_cyc(3);
        #2 check("reset_kd", kd, 5'h1F);
        check("reset_ok", frame_ok, 0);
        check("reset_err", frame_err, 0);
        @(negedge clk) rst_n = 1'b1;
        wait_cyc(4);

        do_frame("row0", 8'h50, 40'h00_0000_0001, 48, 1'b0);
        for (int i = 0; i < 3; i++) apply_table("row0_kd", t1[i]);

        do_frame("two_rows", 8'h50, 40'h80_0000_0001, 48, 1'b0);
        for (int i = 0; i < 3; i++) apply_table("two_rows_kd", t2[i]);

        do_frame("short47", 8'h50, 40'hFF_FFFF_FFFF, 47, 1'b0);
        for (int i = 0; i < 3; i++) apply_table("short47_kd", t2[i]);

        do_frame("long64", 8'h50, 40'hFF_FFFF_FFFF, 64, 1'b0);
        for (int i = 0; i < 3; i++) apply_table("long64_kd", t2[i]);

        do_frame("badsig", 8'h30, 40'hFF_FFFF_FFFF, 48, 1'b0);
        for (int i = 0; i < 3; i++) apply_table("badsig_kd", t2[i]);

        do_frame("after_bad", 8'h5A, 40'h12_3456_789A, 48, 1'b0);
        for (int r = 0; r < 8; r++) check_model("after_bad_row", ~(8'h01 << r));

        // reset in the middle of a frame
        o0 = ok_cnt;
        e0 = err_cnt;
        a_hi = 8'h00;
        @(negedge clk) cs = 1'b0;
        wait_cyc(4);
        for (int k = 0; k < 20; k++) spi_bit(1'b1);
        @(negedge clk) rst_n = 1'b0;
        #2 check("midreset_kd", kd, 5'h1F);
        model_clear();
        cs = 1'b1;
        sclk = 1'b0;
        di = 1'b0;
        wait_cyc(5);
        @(negedge clk) rst_n = 1'b1;
        wait_cyc(6);
        check("midreset_no_ok", ok_cnt - o0, 0);
        check("midreset_no_err", err_cnt - e0, 0);
        do_frame("post_reset", 8'h55, 40'h00_0F0F_0F0F, 48, 1'b0);
        for (int r = 0; r < 8; r++) check_model("post_reset_row", ~(8'h01 << r));

        // clock activity while deselected, then a sub-cycle pulse inside a frame
        for (int i = 0; i < 5; i++) begin
            @(negedge clk) sclk = 1'b1;
            wait_cyc(4);
            @(negedge clk) sclk = 1'b0;
            wait_cyc(4);
        end
        do_frame("glitch", 8'h50, 40'h84_2108_4210, 48, 1'b1);
        for (int r = 0; r < 8; r++) check_model("glitch_row", ~(8'h01 << r));

        for (int f = 0; f < 30; f++) begin
            sel = $urandom_range(0, 9);
            n = (sel == 0) ? 47 : (sel == 1) ? 49 : (sel == 2) ? 64 : 48;
            hdr = {4'b0101, 4'($urandom)};
            if (sel == 3) begin
                hdr = 8'($urandom);
                if (hdr[7:4] == 4'b0101) hdr[7] = 1'b1;
            end
            pl = {8'($urandom), 32'($urandom)};
            do_frame("rand_frame", hdr, pl, n, 1'b0);
            for (int j = 0; j < 4; j++) check_model("rand_kd", 8'($urandom));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
